// File: rtl/mult_pkg.sv
// Shared types and defaults for the shift-add signed multiplier controller.
package mult_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int CNT_W     = $clog2(WIDTH_DEF);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLR   = 3'd1,
    ADD   = 3'd2,
    SHIFT = 3'd3,
    HOLD  = 3'd4
  } state_t;

endpackage

// File: rtl/mult_step_cnt.sv
// Iteration counter: sync clear, enable-increment, flags the final iteration.
module mult_step_cnt #(
  parameter int WIDTH = 8,
  parameter int CW    = 3
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic inc_i,
  output logic last_o
);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni || clr_i) cnt_q <= '0;
    else if (inc_i)       cnt_q <= cnt_q + 1'b1;
  end

  assign last_o = (cnt_q == CW'(WIDTH - 1));

endmodule

// File: rtl/mult_control.sv
// Sequencer for the shift-add signed multiplier: one CLR, then WIDTH ADD/SHIFT
// pairs, the final ADD subtracting so the result is two's-complement.
module mult_control
  import mult_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic Clk,
  input  logic Reset_n,
  input  logic Run,
  input  logic ClearA_LoadB,
  input  logic M,
  output logic Clr_XA,
  output logic Ld_B,
  output logic Ld_XA,
  output logic Sub,
  output logic Shift_En,
  output logic Busy,
  output logic Done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t state_q, state_d;
  logic   cnt_clr, cnt_inc, last;

  mult_step_cnt #(.WIDTH(WIDTH), .CW(CW)) u_cnt (
    .clk_i  (Clk),
    .rst_ni (Reset_n),
    .clr_i  (cnt_clr),
    .inc_i  (cnt_inc),
    .last_o (last)
  );

  always_ff @(posedge Clk) begin
    if (!Reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    Clr_XA   = 1'b0;
    Ld_B     = 1'b0;
    Ld_XA    = 1'b0;
    Sub      = 1'b0;
    Shift_En = 1'b0;
    Busy     = 1'b0;
    Done     = 1'b0;
    cnt_clr  = 1'b0;
    cnt_inc  = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Run wins over a simultaneous load request
        if (Run) begin
          state_d = CLR;
        end else if (ClearA_LoadB) begin
          Clr_XA = 1'b1;
          Ld_B   = 1'b1;
        end
      end
      CLR: begin
        Clr_XA  = 1'b1;
        Busy    = 1'b1;
        cnt_clr = 1'b1;
        state_d = ADD;
      end
      ADD: begin
        Ld_XA   = M;
        Sub     = M & last;
        Busy    = 1'b1;
        state_d = SHIFT;
      end
      SHIFT: begin
        Shift_En = 1'b1;
        Busy     = 1'b1;
        if (last) begin
          state_d = HOLD;
        end else begin
          cnt_inc = 1'b1;
          state_d = ADD;
        end
      end
      HOLD: begin
        Done = 1'b1;
        if (!Run) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mult_control.sv
// Scoreboard bench for mult_control with a behavioural X:A:B datapath attached.
module tb_mult_control;

  logic Clk = 1'b0;
  logic Reset_n, Run, ClearA_LoadB, M;
  logic Clr_XA, Ld_B, Ld_XA, Sub, Shift_En, Busy, Done;

  mult_control #(.WIDTH(8)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Run(Run), .ClearA_LoadB(ClearA_LoadB), .M(M),
    .Clr_XA(Clr_XA), .Ld_B(Ld_B), .Ld_XA(Ld_XA), .Sub(Sub),
    .Shift_En(Shift_En), .Busy(Busy), .Done(Done)
  );

  always #5 Clk = ~Clk;

  // datapath model driven by the strobes
  logic [7:0] A_m = '0, B_m = '0, S = '0, SW = '0;
  logic       X_m = 1'b0;
  logic [8:0] sum;
  assign M   = B_m[0];
  assign sum = Sub ? ({A_m[7], A_m} - {S[7], S}) : ({A_m[7], A_m} + {S[7], S});

  always @(posedge Clk) begin
    if (Clr_XA) begin A_m <= '0; X_m <= 1'b0; end
    if (Ld_B) B_m <= SW;
    if (Ld_XA) begin X_m <= sum[8]; A_m <= sum[7:0]; end
    if (Shift_En) begin A_m <= {X_m, A_m[7:1]}; B_m <= {A_m[0], B_m[7:1]}; end
  end

  typedef struct {
    logic [6:0] v;
    string      n;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] prod_q[$];
  int          checks = 0;
  int          errors = 0;
  logic        done_d = 1'b0;

  wire [6:0] outv = {Clr_XA, Ld_B, Ld_XA, Sub, Shift_En, Busy, Done};

  // {Clr_XA, Ld_B, Ld_XA, Sub, Shift_En, Busy, Done}
  localparam logic [6:0] V_ZERO  = 7'b0000000;
  localparam logic [6:0] V_LOAD  = 7'b1100000;
  localparam logic [6:0] V_CLR   = 7'b1000010;
  localparam logic [6:0] V_SHIFT = 7'b0000110;
  localparam logic [6:0] V_DONE  = 7'b0000001;

  function automatic logic [6:0] v_add(input logic m, input logic lst);
    return {2'b00, m, m & lst, 3'b010};
  endfunction

  always @(negedge Clk) begin
    exp_t e;
    logic [15:0] p;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (outv !== e.v) begin
        errors++;
        $display("FAIL %s: got %b expected %b", e.n, outv, e.v);
      end
    end
    if (Done && !done_d) begin
      checks++;
      if (prod_q.size() == 0) begin
        errors++;
        $display("FAIL product: Done with no run pending, got %h", {A_m, B_m});
      end else begin
        p = prod_q.pop_front();
        if ({A_m, B_m} !== p) begin
          errors++;
          $display("FAIL product: got %h expected %h", {A_m, B_m}, p);
        end
      end
    end
    done_d <= Done;
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic expect_v(input logic [6:0] v, input string n);
    exp_t e;
    e.v = v;
    e.n = n;
    exp_q.push_back(e);
  endtask

  task automatic load_b(input logic [7:0] v);
    SW = v; ClearA_LoadB = 1'b1;
    expect_v(V_LOAD, "load");
    tick();
    ClearA_LoadB = 1'b0;
    expect_v(V_ZERO, "load_end");
    tick();
  endtask

  task automatic run_op(input logic [7:0] s, input logic [7:0] bm, input logic [15:0] prod,
                        input bit pulse, input bit prio, input int extra);
    S = s;
    prod_q.push_back(prod);
    Run = 1'b1; ClearA_LoadB = prio; SW = 8'h55;
    expect_v(V_ZERO, prio ? "prio_start" : "run_start");
    tick();
    ClearA_LoadB = 1'b0;
    if (pulse) Run = 1'b0;
    expect_v(V_CLR, "clr");
    tick();
    for (int i = 0; i < 8; i++) begin
      expect_v(v_add(bm[i], i == 7), "add");
      tick();
      expect_v(V_SHIFT, "shift");
      tick();
    end
    repeat (extra) begin
      expect_v(V_DONE, "hold");
      tick();
    end
    Run = 1'b0;
    expect_v(V_DONE, "hold_last");
    tick();
    expect_v(V_ZERO, "back_idle");
    tick();
  endtask

  initial begin
    Reset_n = 1'b0; Run = 1'b0; ClearA_LoadB = 1'b0;
    tick();
    Reset_n = 1'b1;
    expect_v(V_ZERO, "reset_state");
    tick();

    // 3 * -1 with all M=1, then Run held 5 cycles past Done
    load_b(8'hFF);
    run_op(8'h03, 8'hFF, 16'hFFFD, 1'b0, 1'b0, 5);

    // 7 * -2, Run and ClearA_LoadB together: B must not reload from 0x55
    load_b(8'hFE);
    run_op(8'h07, 8'hFE, 16'hFFF2, 1'b0, 1'b1, 0);

    // -128 * -128 with a single-cycle Run pulse
    load_b(8'h80);
    run_op(8'h80, 8'h80, 16'h4000, 1'b1, 1'b0, 0);

    // reset during the ADD of cnt==3 with Run still high
    load_b(8'hFF);
    S = 8'h01; Run = 1'b1;
    expect_v(V_ZERO, "rst_run_start");
    tick();
    expect_v(V_CLR, "rst_clr");
    tick();
    for (int i = 0; i < 3; i++) begin
      expect_v(v_add(1'b1, 1'b0), "rst_add");
      tick();
      expect_v(V_SHIFT, "rst_shift");
      tick();
    end
    Reset_n = 1'b0;
    expect_v(v_add(1'b1, 1'b0), "rst_add3");
    tick();
    Reset_n = 1'b1; Run = 1'b0;
    expect_v(V_ZERO, "after_reset");
    tick();
    expect_v(V_ZERO, "after_reset_idle");
    tick();

    for (int k = 0; k < 5 && exp_q.size() > 0; k++) @(negedge Clk);
    #1;
    if (exp_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    if (prod_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL product_drain: %0d products never seen, required 0", prod_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
